wb_trace_fifo: RTL and testbench

//   Captures register-file writeback events from the single-cycle CPU and buffers them
//   for a downstream logger or bench monitor through a valid/ready stream.

---
 rtl/wb_trace_fifo.sv | 85 ++++++++
 tb/tb_wb_trace_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: records {cycle, reg, data} for every non-r0 register write.
// Latency: one edge from push to trace_valid_o. Backpressure: full FIFO drops events and counts them.
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              trace_valid_o,
  input  logic              trace_ready_i,
  output logic [CNT_W-1:0]  trace_cycle_o,
  output logic [ADDR_W-1:0] trace_addr_o,
  output logic [DATA_W-1:0] trace_data_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam int IDX_W = LVL_W - 1;
  localparam int ENT_W = CNT_W + ADDR_W + DATA_W;

  logic [LVL_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_overflow;
  logic [ENT_W-1:0] r_mem [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [ENT_W-1:0] w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                      (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
  assign w_pop      = !w_empty && trace_ready_i;
  assign w_push_req = wb_en_i && (wb_addr_i != '0);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cycle    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_W'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LVL_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= {r_cycle, wb_addr_i, wb_data_i};
  end

  // Head is masked while empty so reset and idle both present zeros.
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[IDX_W-1:0]];

  assign trace_valid_o = !w_empty;
  assign trace_cycle_o = w_head[ENT_W-1 -: CNT_W];
  assign trace_addr_o  = w_head[DATA_W +: ADDR_W];
  assign trace_data_o  = w_head[DATA_W-1:0];
  assign level_o       = r_wr_ptr - r_rd_ptr;
  assign overflow_o    = r_overflow;
  assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomised and directed bench for wb_trace_fifo against a queue-based reference model.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [15:0] trace_cycle_o;
  logic [4:0]  trace_addr_o;
  logic [31:0] trace_data_o;
  logic [4:0]  level_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  wb_trace_fifo #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_cycle_o(trace_cycle_o), .trace_addr_o(trace_addr_o), .trace_data_o(trace_data_o),
    .level_o(level_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [15:0] m_cyc;
  logic        m_ovf;
  logic [15:0] m_drop;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cyc  = '0;
    m_ovf  = 1'b0;
    m_drop = '0;
  endtask

  task automatic model_step(input logic en, input logic [4:0] a, input logic [31:0] d,
                            input logic rdy);
    ent_t e;
    bit   was_full = (m_q.size() == DEPTH);
    bit   pop      = rdy && (m_q.size() != 0);
    if (pop) e = m_q.pop_front();
    if (en && a != 0) begin
      if (!was_full || pop) begin
        e.cyc = m_cyc; e.addr = a; e.data = d;
        m_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    m_cyc = m_cyc + 16'd1;
  endtask

  task automatic check_all();
    chk("valid", 64'(trace_valid_o), 64'(m_q.size() != 0));
    chk("level", 64'(level_o), 64'(m_q.size()));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
    if (m_q.size() != 0) begin
      chk("head_cycle", 64'(trace_cycle_o), 64'(m_q[0].cyc));
      chk("head_addr", 64'(trace_addr_o), 64'(m_q[0].addr));
      chk("head_data", 64'(trace_data_o), 64'(m_q[0].data));
    end
  endtask

  // Drive after a falling edge, update model on the rising edge, compare on the next falling edge.
  task automatic cyc(input logic en, input logic [4:0] a, input logic [31:0] d, input logic rdy);
    wb_en_i = en; wb_addr_i = a; wb_data_i = d; trace_ready_i = rdy;
    @(posedge clk_i);
    model_step(en, a, d, rdy);
    @(negedge clk_i);
    check_all();
  endtask

  initial begin
    rst_i = 1'b1; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0; trace_ready_i = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", 64'(trace_valid_o), 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    chk("rst_data", 64'(trace_data_o), 64'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;

    // First write lands on edge 3 after release.
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0);
    cyc(1'b1, 5'd1, 32'd5, 1'b0);
    chk("t1_valid", 64'(trace_valid_o), 64'd1);
    chk("t1_addr", 64'(trace_addr_o), 64'd1);
    chk("t1_data", 64'(trace_data_o), 64'd5);
    chk("t1_cycle", 64'(trace_cycle_o), 64'd3);
    chk("t1_level", 64'(level_o), 64'd1);
    cyc(1'b0, 5'd0, 32'd0, 1'b1);

    for (int i = 0; i < 10; i++) cyc(1'b1, 5'd0, 32'd7, 1'b0);
    chk("t2_valid", 64'(trace_valid_o), 64'd0);
    chk("t2_level", 64'(level_o), 64'd0);
    chk("t2_drop", 64'(drop_cnt_o), 64'd0);

    for (int i = 1; i <= 18; i++) cyc(1'b1, 5'(i), 32'(i * 3 + 100), 1'b0);
    chk("t3_level", 64'(level_o), 64'd16);
    chk("t3_ovf", 64'(overflow_o), 64'd1);
    chk("t3_drop", 64'(drop_cnt_o), 64'd2);
    chk("t3_head", 64'(trace_addr_o), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_order", 64'(trace_addr_o), 64'(i + 1));
      cyc(1'b0, 5'd0, 32'd0, 1'b1);
    end

    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 5'(i), $urandom, 1'b0);
    cyc(1'b1, 5'd20, 32'hABCD, 1'b1);
    chk("t4_level", 64'(level_o), 64'd16);
    chk("t4_drop", 64'(drop_cnt_o), 64'd2);
    for (int k = 0; k < DEPTH; k++) begin
      chk("t4_order", 64'(trace_addr_o), 64'((k < DEPTH - 1) ? k + 2 : 20));
      cyc(1'b0, 5'd0, 32'd0, 1'b1);
    end

    for (int i = 0; i < 4; i++) cyc(1'b1, 5'(i + 7), $urandom, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 5'd0, 32'd0, 1'b0);
      chk("t5_hold_addr", 64'(trace_addr_o), 64'd7);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 5'd0, 32'd0, 1'b1);
      chk("t5_drain", 64'(level_o), 64'(3 - i));
    end

    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 9) < 4));

    for (int i = 0; i < DEPTH + 2 && m_q.size() != 0; i++) cyc(1'b0, 5'd0, 32'd0, 1'b1);
    chk("t6_empty", 64'(level_o), 64'd0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 5'(i + 2), $urandom, 1'b0);
    chk("t6_level6", 64'(level_o), 64'd6);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_async_valid", 64'(trace_valid_o), 64'd0);
    chk("t6_async_level", 64'(level_o), 64'd0);
    chk("t6_async_data", 64'(trace_data_o), 64'd0);
    chk("t6_async_ovf", 64'(overflow_o), 64'd0);
    chk("t6_async_drop", 64'(drop_cnt_o), 64'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc(1'b1, 5'd3, 32'd7, 1'b0);
    chk("t6_first_stamp", 64'(trace_cycle_o), 64'd0);
    chk("t6_level", 64'(level_o), 64'd1);
    for (int i = 0; i < 40; i++)
      cyc(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 1) == 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
